// File: rtl/pb_pkg.sv
// Shared types, default timing constants and counter sizing for the pushbutton conditioner.
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } rep_state_t;

  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One pushbutton: two-flop synchronizer, counter debouncer and auto-repeat FSM.
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic key_event
);

  localparam int DCW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RCW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [DCW-1:0] DB_LAST     = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic           sync1_reg, sync2_reg;
  logic           raw;
  logic           stable_reg, stable_next;
  logic [DCW-1:0] dcnt_reg, dcnt_next;
  logic           press_next, release_next;
  rep_state_t     state_reg, state_next;
  logic [RCW-1:0] rcnt_reg, rcnt_next;
  logic           strobe_next;

  // Synchronizer flops idle at 1 so reset reads as "released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
    end
  end

  assign raw = ~sync2_reg;

  always_comb begin
    stable_next  = stable_reg;
    dcnt_next    = dcnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    if (raw == stable_reg) begin
      dcnt_next = '0;
    end else if (dcnt_reg == DB_LAST) begin
      stable_next  = raw;
      dcnt_next    = '0;
      press_next   = raw;
      release_next = ~raw;
    end else begin
      dcnt_next = dcnt_reg + DCW'(1);
    end
  end

  // The FSM reacts to the debouncer's next-cycle events so the first repeat
  // lands exactly REPEAT_DELAY cycles after the registered press pulse.
  always_comb begin
    state_next  = state_reg;
    rcnt_next   = rcnt_reg;
    strobe_next = 1'b0;
    if (state_reg == IDLE) begin
      if (press_next) begin
        state_next = repeat_en ? DELAY : HELD;
        rcnt_next  = '0;
      end
    end else if (release_next) begin
      state_next = IDLE;
      rcnt_next  = '0;
    end else if (!repeat_en) begin
      state_next = HELD;
      rcnt_next  = '0;
    end else begin
      case (state_reg)
        HELD: begin
          state_next = DELAY;
          rcnt_next  = '0;
        end
        DELAY: begin
          if (rcnt_reg == DELAY_LAST) begin
            strobe_next = 1'b1;
            state_next  = REPEAT;
            rcnt_next   = '0;
          end else begin
            rcnt_next = rcnt_reg + RCW'(1);
          end
        end
        REPEAT: begin
          if (rcnt_reg == PERIOD_LAST) begin
            strobe_next = 1'b1;
            rcnt_next   = '0;
          end else begin
            rcnt_next = rcnt_reg + RCW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_reg    <= 1'b0;
      dcnt_reg      <= '0;
      state_reg     <= IDLE;
      rcnt_reg      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      key_event     <= 1'b0;
    end else begin
      stable_reg    <= stable_next;
      dcnt_reg      <= dcnt_next;
      state_reg     <= state_next;
      rcnt_reg      <= rcnt_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      key_event     <= press_next | strobe_next;
    end
  end

  assign btn_level = stable_reg;

endmodule

// File: rtl/pb_conditioner.sv
// KEY[3:0] conditioner: one independent channel per button, outputs packed per bit.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                repeat_en,
  output logic [NUM_KEYS-1:0] btn_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] key_event
);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      pb_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_n        (key_n[gi]),
        .repeat_en    (repeat_en),
        .btn_level    (btn_level[gi]),
        .press_pulse  (press_pulse[gi]),
        .release_pulse(release_pulse[gi]),
        .key_event    (key_event[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with a per-cycle behavioural model and literal timing checks.
module tb_pb_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic          repeat_en = 1'b0;
  logic [NK-1:0] btn_level, press_pulse, release_pulse, key_event;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pb_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .repeat_en(repeat_en),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .key_event(key_event)
  );

  // Model: raw at an edge is the key_n seen two edges earlier; a change is
  // accepted after DB consecutive disagreeing edges; repeats are scheduled
  // by absolute edge number.
  logic [NK-1:0] kn_d1, kn_d2;
  logic [NK-1:0] m_level, m_press, m_rel, m_evt;
  int run [NK];
  int next_rep [NK];
  int tick;

  task automatic model_reset();
    kn_d1 = '1; kn_d2 = '1;
    m_level = '0; m_press = '0; m_rel = '0; m_evt = '0;
    tick = 0;
    for (int i = 0; i < NK; i++) begin
      run[i] = 0;
      next_rep[i] = -1;
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] raw;
    logic was_held, strobe;
    raw = ~kn_d2;
    kn_d2 = kn_d1;
    kn_d1 = key_n;
    tick++;
    for (int i = 0; i < NK; i++) begin
      was_held = m_level[i];
      strobe = 1'b0;
      m_press[i] = 1'b0;
      m_rel[i] = 1'b0;
      if (raw[i] == m_level[i]) run[i] = 0;
      else begin
        run[i]++;
        if (run[i] == DB) begin
          m_level[i] = raw[i];
          run[i] = 0;
          m_press[i] = raw[i];
          m_rel[i] = ~raw[i];
        end
      end
      if (m_rel[i]) next_rep[i] = -1;
      else if (m_press[i]) next_rep[i] = repeat_en ? tick + RD : -1;
      else if (was_held) begin
        if (!repeat_en) next_rep[i] = -1;
        else if (next_rep[i] == -1) next_rep[i] = tick + RD;
        else if (tick == next_rep[i]) begin
          strobe = 1'b1;
          next_rep[i] = tick + RP;
        end
      end
      m_evt[i] = m_press[i] | strobe;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if ({btn_level, press_pulse, release_pulse, key_event} !== {m_level, m_press, m_rel, m_evt}) begin
        errors++;
        $display("FAIL model_cmp cyc=%0d got lvl=%b prs=%b rel=%b evt=%b want lvl=%b prs=%b rel=%b evt=%b",
                 cyc, btn_level, press_pulse, release_pulse, key_event, m_level, m_press, m_rel, m_evt);
      end
      if (press_pulse[1] | release_pulse[1]) pulse_cnt1++;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cyc=%0d)", name, got, want, cyc);
    end else begin
      $display("ok   %s = %0d (cyc=%0d)", name, got, cyc);
    end
  endtask

  // sel: 0 press, 1 release, 2 key_event, 3 btn_level
  task automatic wait_bit(input int sel, input int idx, input int budget, output int edge_no);
    logic [NK-1:0] v;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      case (sel)
        0: v = press_pulse;
        1: v = release_pulse;
        2: v = key_event;
        default: v = btn_level;
      endcase
      if (v[idx]) begin
        edge_no = cyc;
        return;
      end
    end
    checks++;
    errors++;
    edge_no = -1;
    $display("FAIL wait sel=%0d key=%0d got=timeout want=event within %0d cycles", sel, idx, budget);
  endtask

  int k, e, p, h, r;
  int offs[$];
  int exp_off [8] = '{0, 10, 13, 16, 19, 22, 25, 28};

  initial begin
    // Reset
    tick_n(3);
    check("reset_outputs", {btn_level, press_pulse, release_pulse, key_event}, 0);
    reset_n = 1'b1;
    tick_n(2);

    // Clean press/release on key 0
    key_n[0] = 1'b0;
    k = cyc + 1;
    wait_bit(0, 0, 20, e);
    check("press_latency0", e - k, DB + 1);
    @(negedge clk);
    check("press_width0", press_pulse[0], 0);
    check("level_held0", btn_level[0], 1);
    tick_n(3);
    key_n[0] = 1'b1;
    k = cyc + 1;
    wait_bit(1, 0, 20, e);
    check("release_latency0", e - k, DB + 1);

    // Bounce rejection on key 1
    tick_n(1);
    h = 0;
    for (int b = 0; b < 20; b++) begin
      key_n[1] = 1'b0;
      tick_n(3);
      key_n[1] = 1'b1;
      h = cyc + 1;
      tick_n(1);
    end
    check("bounce_level1", btn_level[1], 0);
    check("bounce_pulses1", pulse_cnt1, 0);
    key_n[1] = 1'b0;
    wait_bit(0, 1, 20, e);
    check("bounce_accept1", e - h, 6);
    tick_n(1);
    key_n[1] = 1'b1;
    wait_bit(1, 1, 20, e);

    // Auto-repeat on key 2
    tick_n(1);
    repeat_en = 1'b1;
    key_n[2] = 1'b0;
    wait_bit(0, 2, 20, p);
    if (key_event[2]) offs.push_back(0);
    for (int o = 1; o <= 45; o++) begin
      @(posedge clk);
      #1;
      if (cyc == p + 24) key_n[2] = 1'b1;
      @(negedge clk);
      if (key_event[2]) offs.push_back(cyc - p);
    end
    check("repeat_count2", offs.size(), 8);
    for (int j = 0; j < 8 && j < offs.size(); j++) check($sformatf("repeat_off2_%0d", j), offs[j], exp_off[j]);

    // Repeat disabled during press, enabled 5 cycles later
    repeat_en = 1'b0;
    tick_n(1);
    key_n[2] = 1'b0;
    wait_bit(0, 2, 20, p);
    tick_n(4);
    repeat_en = 1'b1;
    wait_bit(2, 2, 30, e);
    check("late_enable_repeat2", e - p, 15);
    repeat_en = 1'b0;
    tick_n(1);
    key_n[2] = 1'b1;
    wait_bit(1, 2, 20, e);

    // Reset while key 3 is auto-repeating
    tick_n(1);
    repeat_en = 1'b1;
    key_n[3] = 1'b0;
    wait_bit(0, 3, 20, p);
    wait_bit(2, 3, 20, e);
    wait_bit(2, 3, 20, e);
    check("reached_repeat3", e - p, RD + RP);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_async_outputs", {btn_level, press_pulse, release_pulse, key_event}, 0);
    tick_n(3);
    reset_n = 1'b1;
    r = cyc;
    wait_bit(0, 3, 20, e);
    check("repress_after_reset3", e - r, 6);

    // Simultaneous press on keys 0 and 3
    repeat_en = 1'b0;
    tick_n(1);
    key_n[3] = 1'b1;
    wait_bit(1, 3, 20, e);
    tick_n(2);
    key_n[0] = 1'b0;
    key_n[3] = 1'b0;
    wait_bit(0, 0, 20, e);
    check("simul_press", press_pulse, 4'b1001);
    tick_n(2);
    key_n = '1;
    wait_bit(1, 0, 20, e);
    check("simul_release", release_pulse, 4'b1001);
    tick_n(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
